// File: rtl/flash_word_fetcher.sv
// Single-word Avalon-MM read responder for the audio playback path.
// One read is in flight at a time, one request can wait behind it, and a read the flash never answers is aborted.
module flash_word_fetcher #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 23
) (
  input  logic              clk22K,
  input  logic              reset,
  input  logic              read_req,
  input  logic [ADDR_W-1:0] read_addr,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  output logic [5:0]        flash_mem_burstcount,
  input  logic              flash_mem_waitrequest,
  input  logic              flash_mem_readdatavalid,
  input  logic [31:0]       flash_mem_readdata,
  output logic [31:0]       flash_data,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        tmo_cnt;
  logic              tmo_hit;

  assign flash_mem_byteenable = 4'hF;
  assign flash_mem_burstcount = 6'd1;
  assign busy                 = (state != IDLE) | pend_valid;
  // A completion in the last allowed cycle still wins over the abort.
  assign tmo_hit              = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk22K or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      flash_mem_read    <= 1'b0;
      flash_mem_address <= '0;
      flash_data        <= 32'h0;
      data_valid        <= 1'b0;
      overrun           <= 1'b0;
      timeout_err       <= 1'b0;
      pend_valid        <= 1'b0;
      pend_addr         <= '0;
      tmo_cnt           <= 8'd0;
    end else begin
      data_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (pend_valid) begin
            flash_mem_address <= pend_addr;
            flash_mem_read    <= 1'b1;
            pend_valid        <= 1'b0;
            tmo_cnt           <= 8'd0;
            state             <= ISSUE;
          end else if (read_req) begin
            flash_mem_address <= read_addr;
            flash_mem_read    <= 1'b1;
            tmo_cnt           <= 8'd0;
            state             <= ISSUE;
          end
        end

        ISSUE: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (!flash_mem_waitrequest && flash_mem_readdatavalid) begin
            flash_mem_read <= 1'b0;
            flash_data     <= flash_mem_readdata;
            data_valid     <= 1'b1;
            state          <= DONE;
          end else if (tmo_hit) begin
            flash_mem_read <= 1'b0;
            flash_data     <= 32'h0;
            data_valid     <= 1'b1;
            timeout_err    <= 1'b1;
            state          <= DONE;
          end else if (!flash_mem_waitrequest) begin
            flash_mem_read <= 1'b0;
            state          <= WAIT_DATA;
          end
        end

        WAIT_DATA: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (flash_mem_readdatavalid) begin
            flash_data <= flash_mem_readdata;
            data_valid <= 1'b1;
            state      <= DONE;
          end else if (tmo_hit) begin
            flash_data  <= 32'h0;
            data_valid  <= 1'b1;
            timeout_err <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase

      // A request that IDLE did not take directly lands in the slot; the slot refills even as IDLE consumes it.
      if (read_req && !(state == IDLE && !pend_valid)) begin
        if (pend_valid && state != IDLE) begin
          overrun <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_addr  <= read_addr;
        end
      end
    end
  end

endmodule

// File: doc/flash_word_fetcher.md
# flash_word_fetcher

Read-side responder for the audio playback path. Accepts single-word read requests (word address plus one-cycle strobe) from the audio address counter, runs one Avalon-MM read transaction per request against the flash controller, and returns the 32-bit word on a held output register with a one-cycle valid strobe. Holds one pending request while a read is in flight, and flags a timeout if the flash controller never responds.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: clk22K cycles allowed from read issue to readdatavalid before abort; range 1..255.
- ADDR_W, 23: word address width.

Ports:
- clk22K  in  1  sample clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- read_req  in  1  one-cycle request strobe from the address counter.
- read_addr  in  ADDR_W  word address; sampled only in a cycle where read_req=1.
- flash_mem_read  out  1  Avalon read command.
- flash_mem_address  out  ADDR_W  Avalon word address.
- flash_mem_byteenable  out  4  constant 4'hF.
- flash_mem_burstcount  out  6  constant 6'd1.
- flash_mem_waitrequest  in  1  Avalon stall.
- flash_mem_readdatavalid  in  1  Avalon read data strobe.
- flash_mem_readdata  in  32  Avalon read data.
- flash_data  out  32  last returned word; held until the next completion.
- data_valid  out  1  one-cycle pulse when flash_data updates.
- busy  out  1  high while a transaction or pending request exists.
- overrun  out  1  sticky; request dropped because the pending slot was full.
- timeout_err  out  1  sticky; a read exceeded TIMEOUT_CYCLES.

## Operation
- States: IDLE, ISSUE, WAIT_DATA, DONE.
- IDLE: if pend_valid, load the pending address; otherwise, if read_req, load read_addr. Loading sets flash_mem_address and goes to ISSUE. A pending request takes priority over a new one. A new read_req in the same cycle goes to the pending slot.
- ISSUE: flash_mem_read=1. The command is accepted in the first cycle where flash_mem_waitrequest=0. Deassert flash_mem_read the next cycle and go to WAIT_DATA. Address is held stable while read=1.
- WAIT_DATA: on flash_mem_readdatavalid=1, load flash_data from flash_mem_readdata and go to DONE. If readdatavalid arrives in the same cycle that the command is accepted, capture it and go directly to DONE.
- DONE: data_valid=1 for exactly one cycle, then return to IDLE.
- Pending slot: one entry (pend_valid, pend_addr).
  - read_req outside IDLE with the slot empty: fills the slot.
  - read_req with the slot full: the request is dropped and overrun=1.
  - The slot is consumed in IDLE.
- Timeout: an 8-bit counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT_DATA. When it reaches TIMEOUT_CYCLES:
  - flash_mem_read drops and the FSM goes to DONE.
  - flash_data is loaded with 32'h0 (silence) and timeout_err=1.
  - Late readdatavalid outside WAIT_DATA is ignored.
- busy = (state != IDLE) | pend_valid.
- overrun and timeout_err clear only on reset.

## Timing
- Reset values: state IDLE, flash_mem_read 0, flash_mem_address 0, flash_data 32'h0, data_valid 0, busy 0, overrun 0, timeout_err 0, pend_valid 0, counter 0. Reset asserted mid-transaction aborts immediately; a late readdatavalid after reset release is ignored.
- Minimum latency, read_req to data_valid, with waitrequest=0 and readdatavalid one cycle after acceptance:
  - cycle 0: req
  - cycle 1: ISSUE, read=1
  - cycle 2: WAIT_DATA, readdatavalid
  - cycle 3: DONE, data_valid=1
  - This is 3 cycles. Each waitrequest cycle or readdatavalid delay cycle adds one.
- Back-to-back: a pending request issues 2 cycles after the previous data_valid (DONE → IDLE → ISSUE).
- flash_data changes only in the cycle data_valid is asserted.
- flash_mem_byteenable and flash_mem_burstcount are constant at all times, including reset.

## Test plan
- Single read: after reset, read_req with read_addr=23'h00010; flash returns 32'hDEADBEEF one cycle after accept.
  - Required: flash_mem_address=23'h00010 with read=1 for one cycle.
  - Required: data_valid at cycle 3, flash_data=32'hDEADBEEF, busy low at cycle 4.
- Waitrequest stall: waitrequest=1 for 4 cycles.
  - Required: read and address held 5 cycles, then drop.
  - Required: data_valid 4 cycles later than the unstalled case.
- Pending and overrun: three read_req at addresses 1, 2, 3 on consecutive cycles while the first read is in flight.
  - Required: addresses 1 then 2 are read in order, and address 3 never appears on flash_mem_address.
  - Required: overrun=1 and stays set.
- Timeout: TIMEOUT_CYCLES=8, readdatavalid never asserted.
  - Required: data_valid at the timeout, flash_data=0, timeout_err=1.
  - Required: a readdatavalid injected afterwards does not change flash_data.
- Reset mid-read: assert reset during WAIT_DATA.
  - Required: all outputs at reset values asynchronously.
  - Required: the next read_req after release completes normally.
- Same-cycle accept/data: waitrequest=0 with readdatavalid in the issue-accept cycle.
  - Required: data is captured, and data_valid follows on the next cycle.
